// File: rtl/core_seq_pkg.sv
// Shared types for the multi-cycle core sequencer: FSM state and trap cause encodings.
// Also provides small state-classification helpers used by the top and the bench-facing debug port.
package core_seq_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    MEM       = 3'd4,
    WRITEBACK = 3'd5,
    TRAP      = 3'd6
  } seq_state_t;

  typedef enum logic [1:0] {
    NONE         = 2'd0,
    ILLEGAL      = 2'd1,
    IMEM_TIMEOUT = 2'd2,
    DMEM_TIMEOUT = 2'd3
  } trap_cause_t;

  // States in which a memory request is outstanding and the timeout runs.
  function automatic logic is_wait_state(input seq_state_t s);
    return (s == FETCH) || (s == MEM);
  endfunction

  // States that count as the core doing work (excludes parked and trapped).
  function automatic logic is_active_state(input seq_state_t s);
    return (s != IDLE) && (s != TRAP);
  endfunction

endpackage

// File: rtl/core_sequencer_seq_timeout.sv
// Request timeout counter shared by FETCH and MEM: counts cycles without ack while enabled.
// o_expired is asserted in the last allowed cycle only if no ack arrives in that same cycle.
module seq_timeout #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  input  logic i_ack,
  output logic o_expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_count;
  logic             w_stall;

  assign w_stall   = i_enable && !i_ack;
  assign o_expired = w_stall && (r_count == LAST);

  // The count holds at LAST; the expiry moves the FSM out of the wait state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (w_stall && (r_count != LAST)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM for the single-issue core: fetch, decode, execute, memory, writeback.
// Optional performance counters (cycle_count, instret_count) are enabled by defining CORE_SEQ_PERF_EN.
module core_sequencer
  import core_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       trap_clear,
  output logic       imem_req,
  input  logic       imem_ack,
  output logic       ir_load,
  input  logic       dec_is_mem,
  input  logic       dec_writes_rd,
  input  logic       dec_illegal,
  input  logic [4:0] dec_rd,
  output logic       dmem_req,
  input  logic       dmem_ack,
  output logic       rf_read_en,
  output logic       rf_write_en,
  output logic       pc_advance,
  output logic       retire,
  output logic       trap,
  output logic [2:0] dbg_state,
  output logic [1:0] trap_cause
`ifdef CORE_SEQ_PERF_EN
  ,
  output logic [31:0] cycle_count,
  output logic [31:0] instret_count
`endif
);

  // Handshake: imem_req/dmem_req are levels held from entry to FETCH/MEM until the
  // cycle the matching ack is sampled high; an ack seen while its req is low is ignored.

  seq_state_t  r_state;
  seq_state_t  w_next_state;
  trap_cause_t r_cause;
  trap_cause_t w_next_cause;
  logic        r_is_mem;
  logic        r_writes_rd;
  logic [4:0]  r_rd;

  logic w_retire;
  logic w_ack;
  logic w_to_enable;
  logic w_to_clear;
  logic w_expired;

  assign w_to_enable = is_wait_state(r_state);
  assign w_ack       = ((r_state == FETCH) && imem_ack) || ((r_state == MEM) && dmem_ack);
  // Clearing on ack as well means a MEM->FETCH retire starts the next fetch from zero.
  assign w_to_clear  = !w_to_enable || w_ack;

  seq_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk    (clk),
    .i_rst_n  (rst),
    .i_clear  (w_to_clear),
    .i_enable (w_to_enable),
    .i_ack    (w_ack),
    .o_expired(w_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cause <= NONE;
    end else begin
      r_state <= w_next_state;
      r_cause <= w_next_cause;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_is_mem    <= 1'b0;
      r_writes_rd <= 1'b0;
      r_rd        <= 5'd0;
    end else if (r_state == DECODE) begin
      r_is_mem    <= dec_is_mem;
      r_writes_rd <= dec_writes_rd;
      r_rd        <= dec_rd;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_cause = r_cause;
    w_retire     = 1'b0;
    imem_req     = 1'b0;
    ir_load      = 1'b0;
    dmem_req     = 1'b0;
    rf_read_en   = 1'b0;
    rf_write_en  = 1'b0;
    pc_advance   = 1'b0;
    retire       = 1'b0;
    trap         = 1'b0;

    case (r_state)
      IDLE: begin
        if (run) w_next_state = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_load      = 1'b1;
          w_next_state = DECODE;
        end else if (w_expired) begin
          w_next_state = TRAP;
          w_next_cause = IMEM_TIMEOUT;
        end
      end
      DECODE: begin
        rf_read_en = 1'b1;
        if (dec_illegal) begin
          w_next_state = TRAP;
          w_next_cause = ILLEGAL;
        end else begin
          w_next_state = EXECUTE;
        end
      end
      EXECUTE: begin
        if (r_is_mem)         w_next_state = MEM;
        else if (r_writes_rd) w_next_state = WRITEBACK;
        else                  w_retire     = 1'b1;
      end
      MEM: begin
        dmem_req = 1'b1;
        if (dmem_ack) begin
          if (r_writes_rd) w_next_state = WRITEBACK;
          else             w_retire     = 1'b1;
        end else if (w_expired) begin
          w_next_state = TRAP;
          w_next_cause = DMEM_TIMEOUT;
        end
      end
      WRITEBACK: begin
        // x0 is hardwired to zero, so a write to it is suppressed but the op still retires.
        rf_write_en = (r_rd != 5'd0);
        w_retire    = 1'b1;
      end
      TRAP: begin
        trap = 1'b1;
        if (trap_clear) begin
          w_next_state = IDLE;
          w_next_cause = NONE;
        end
      end
      default: begin
        w_next_state = IDLE;
        w_next_cause = NONE;
      end
    endcase

    if (w_retire) begin
      pc_advance   = 1'b1;
      retire       = 1'b1;
      w_next_state = run ? FETCH : IDLE;
    end
  end

  assign dbg_state  = r_state;
  assign trap_cause = r_cause;

`ifdef CORE_SEQ_PERF_EN
  logic [31:0] r_cycle_count;
  logic [31:0] r_instret_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cycle_count   <= 32'd0;
      r_instret_count <= 32'd0;
    end else begin
      if (is_active_state(r_state)) r_cycle_count   <= r_cycle_count + 32'd1;
      if (w_retire)                 r_instret_count <= r_instret_count + 32'd1;
    end
  end

  assign cycle_count   = r_cycle_count;
  assign instret_count = r_instret_count;
`endif

  a_one_req: assert property (@(posedge clk) disable iff (!rst) !(imem_req && dmem_req));
  a_retire_pc: assert property (@(posedge clk) disable iff (!rst) retire == pc_advance);
  a_trap_quiet: assert property (@(posedge clk) disable iff (!rst)
    trap |-> !(imem_req || dmem_req || rf_read_en || rf_write_en || retire));

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer with TIMEOUT_CYCLES=4; perf counters checked when CORE_SEQ_PERF_EN is defined.
module tb_core_sequencer;

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXECUTE = 3'd3;
  localparam logic [2:0] S_MEM = 3'd4, S_WB = 3'd5, S_TRAP = 3'd6;

  logic clk = 1'b0;
  logic rst, run, trap_clear, imem_ack, dec_is_mem, dec_writes_rd, dec_illegal, dmem_ack;
  logic [4:0] dec_rd;
  logic imem_req, ir_load, dmem_req, rf_read_en, rf_write_en, pc_advance, retire, trap;
  logic [2:0] dbg_state;
  logic [1:0] trap_cause;
`ifdef CORE_SEQ_PERF_EN
  logic [31:0] cycle_count, instret_count;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  core_sequencer #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .run(run), .trap_clear(trap_clear),
    .imem_req(imem_req), .imem_ack(imem_ack), .ir_load(ir_load),
    .dec_is_mem(dec_is_mem), .dec_writes_rd(dec_writes_rd), .dec_illegal(dec_illegal),
    .dec_rd(dec_rd), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .rf_read_en(rf_read_en), .rf_write_en(rf_write_en), .pc_advance(pc_advance),
    .retire(retire), .trap(trap), .dbg_state(dbg_state), .trap_cause(trap_cause)
`ifdef CORE_SEQ_PERF_EN
    , .cycle_count(cycle_count), .instret_count(instret_count)
`endif
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    run = 1'b0; trap_clear = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    dec_is_mem = 1'b0; dec_writes_rd = 1'b0; dec_illegal = 1'b0; dec_rd = 5'd0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // From IDLE: request run and advance into the first FETCH cycle.
  task automatic go();
    run = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    run = 1'b1;
    @(posedge clk);
    #3;
    checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", dbg_state, S_IDLE); end
    checks++; if ({imem_req, dmem_req, ir_load, rf_read_en, rf_write_en, pc_advance, retire, trap} !== 8'b0) begin
      errors++; $display("FAIL reset_outputs: got %b want 00000000",
        {imem_req, dmem_req, ir_load, rf_read_en, rf_write_en, pc_advance, retire, trap});
    end
    checks++; if (trap_cause !== 2'd0) begin errors++; $display("FAIL reset_cause: got %0d want 0", trap_cause); end
`ifdef CORE_SEQ_PERF_EN
    checks++; if ({cycle_count, instret_count} !== 64'd0) begin errors++; $display("FAIL reset_perf: got %0d/%0d want 0/0", cycle_count, instret_count); end
`endif
    run = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    #2;
    checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL idle_hold: got %0d want %0d", dbg_state, S_IDLE); end
  endtask

  task automatic test_alu();
    do_reset(); go();
    imem_ack = 1'b1; #2;
    checks++; if ({imem_req, ir_load} !== 2'b11) begin errors++; $display("FAIL alu_fetch: got %b want 11", {imem_req, ir_load}); end
    cyc(); imem_ack = 1'b0; dec_writes_rd = 1'b1; dec_rd = 5'd5; #2;
    checks++; if ({dbg_state, rf_read_en} !== {S_DECODE, 1'b1}) begin errors++; $display("FAIL alu_decode: got %0d/%b want %0d/1", dbg_state, rf_read_en, S_DECODE); end
    cyc(); dec_writes_rd = 1'b0; dec_rd = 5'd0; #2;
    checks++; if ({dbg_state, retire} !== {S_EXECUTE, 1'b0}) begin errors++; $display("FAIL alu_execute: got %0d/%b want %0d/0", dbg_state, retire, S_EXECUTE); end
    cyc(); #2;
    checks++; if ({rf_write_en, retire, pc_advance} !== 3'b111) begin errors++; $display("FAIL alu_writeback: got %b want 111", {rf_write_en, retire, pc_advance}); end
    cyc(); #2;
    checks++; if ({dbg_state, imem_req} !== {S_FETCH, 1'b1}) begin errors++; $display("FAIL alu_next_fetch: got %0d/%b want %0d/1", dbg_state, imem_req, S_FETCH); end
  endtask

  task automatic test_load();
    int n;
    do_reset(); go();
    imem_ack = 1'b1; #2;
    cyc(); imem_ack = 1'b0; dec_is_mem = 1'b1; dec_writes_rd = 1'b1; dec_rd = 5'd7; #2;
    cyc(); dec_is_mem = 1'b0; dec_writes_rd = 1'b0; dec_rd = 5'd0; dmem_ack = 1'b1; #2;
    checks++; if ({dbg_state, dmem_req} !== {S_EXECUTE, 1'b0}) begin errors++; $display("FAIL load_execute: got %0d/%b want %0d/0", dbg_state, dmem_req, S_EXECUTE); end
    n = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(); dmem_ack = (i == 3); #2;
      if (dmem_req && !retire) n++;
    end
    checks++; if (n !== 4) begin errors++; $display("FAIL load_req_cycles: got %0d want 4", n); end
    cyc(); dmem_ack = 1'b0; #2;
    checks++; if ({dbg_state, rf_write_en, retire, pc_advance} !== {S_WB, 3'b111}) begin
      errors++; $display("FAIL load_retire_c8: got %0d/%b want %0d/111", dbg_state, {rf_write_en, retire, pc_advance}, S_WB);
    end
  endtask

  task automatic test_illegal();
    do_reset(); go();
    imem_ack = 1'b1; #2;
    cyc(); imem_ack = 1'b0; dec_illegal = 1'b1; #2;
    checks++; if ({pc_advance, retire} !== 2'b00) begin errors++; $display("FAIL illegal_no_retire: got %b want 00", {pc_advance, retire}); end
    cyc(); dec_illegal = 1'b0; #2;
    checks++; if ({dbg_state, trap, trap_cause, imem_req, pc_advance} !== {S_TRAP, 1'b1, 2'd1, 2'b00}) begin
      errors++; $display("FAIL illegal_trap: got %0d/%b/%0d/%b%b want %0d/1/1/00", dbg_state, trap, trap_cause, imem_req, pc_advance, S_TRAP);
    end
    run = 1'b0;
    cyc(); #2;
    checks++; if ({trap, trap_cause} !== 3'b101) begin errors++; $display("FAIL trap_sticky: got %b/%0d want 1/1", trap, trap_cause); end
    trap_clear = 1'b1;
    cyc(); trap_clear = 1'b0; #2;
    checks++; if ({dbg_state, trap, trap_cause} !== {S_IDLE, 1'b0, 2'd0}) begin
      errors++; $display("FAIL trap_clear: got %0d/%b/%0d want %0d/0/0", dbg_state, trap, trap_cause, S_IDLE);
    end
  endtask

  task automatic test_timeouts();
    int n;
    do_reset(); go();
    n = 0;
    for (int i = 0; i < 4; i++) begin
      #2; if (imem_req && !trap) n++;
      cyc();
    end
    #2;
    checks++; if (n !== 4) begin errors++; $display("FAIL imem_wait_cycles: got %0d want 4", n); end
    checks++; if ({trap, trap_cause, imem_req} !== {1'b1, 2'd2, 1'b0}) begin
      errors++; $display("FAIL imem_timeout: got %b/%0d/%b want 1/2/0", trap, trap_cause, imem_req);
    end
    do_reset(); go();
    repeat (3) cyc();
    imem_ack = 1'b1; #2;
    checks++; if ({ir_load, trap} !== 2'b10) begin errors++; $display("FAIL imem_ack_last: got %b want 10", {ir_load, trap}); end
    cyc(); imem_ack = 1'b0; #2;
    checks++; if ({dbg_state, trap} !== {S_DECODE, 1'b0}) begin errors++; $display("FAIL imem_ack_wins: got %0d/%b want %0d/0", dbg_state, trap, S_DECODE); end
    do_reset(); go();
    imem_ack = 1'b1; #2;
    cyc(); imem_ack = 1'b0; dec_is_mem = 1'b1; #2;
    cyc(); dec_is_mem = 1'b0;
    repeat (5) cyc();
    #2;
    checks++; if ({trap, trap_cause, dmem_req} !== {1'b1, 2'd3, 1'b0}) begin
      errors++; $display("FAIL dmem_timeout: got %b/%0d/%b want 1/3/0", trap, trap_cause, dmem_req);
    end
  endtask

  task automatic test_rd0_run_drop();
    do_reset(); go();
    imem_ack = 1'b1; #2;
    cyc(); imem_ack = 1'b0; dec_is_mem = 1'b1; dec_writes_rd = 1'b1; dec_rd = 5'd0; #2;
    cyc(); dec_is_mem = 1'b0; dec_writes_rd = 1'b0;
    cyc(); run = 1'b0; #2;
    checks++; if ({dbg_state, dmem_req} !== {S_MEM, 1'b1}) begin errors++; $display("FAIL drop_in_mem: got %0d/%b want %0d/1", dbg_state, dmem_req, S_MEM); end
    cyc(); dmem_ack = 1'b1; #2;
    checks++; if (retire !== 1'b0) begin errors++; $display("FAIL mem_ack_to_wb: got %b want 0", retire); end
    cyc(); dmem_ack = 1'b0; #2;
    checks++; if ({rf_write_en, retire, pc_advance} !== 3'b011) begin errors++; $display("FAIL rd0_writeback: got %b want 011", {rf_write_en, retire, pc_advance}); end
    cyc(); #2;
    checks++; if ({dbg_state, imem_req} !== {S_IDLE, 1'b0}) begin errors++; $display("FAIL park_idle: got %0d/%b want %0d/0", dbg_state, imem_req, S_IDLE); end
  endtask

  task automatic test_async_reset();
    do_reset(); go();
    imem_ack = 1'b1; #2;
    cyc(); imem_ack = 1'b0; dec_is_mem = 1'b1; #2;
    cyc(); dec_is_mem = 1'b0;
    cyc(); #2;
    checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL pre_reset_req: got %b want 1", dmem_req); end
    rst = 1'b0;
    #1;
    checks++; if ({dbg_state, dmem_req} !== {S_IDLE, 1'b0}) begin errors++; $display("FAIL async_reset: got %0d/%b want %0d/0", dbg_state, dmem_req, S_IDLE); end
    cyc();
    rst = 1'b1;
  endtask

  task automatic test_back_to_back();
    int n;
    do_reset();
    imem_ack = 1'b1;
    go();
    n = 0;
    for (int i = 0; i < 30; i++) begin
      if (i == 29) run = 1'b0;
      #2; if (retire && pc_advance) n++;
      cyc();
    end
    imem_ack = 1'b0;
    #2;
    checks++; if (n !== 10) begin errors++; $display("FAIL b2b_retires: got %0d want 10", n); end
    checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL b2b_park: got %0d want %0d", dbg_state, S_IDLE); end
`ifdef CORE_SEQ_PERF_EN
    checks++; if (instret_count !== 32'd10) begin errors++; $display("FAIL instret_count: got %0d want 10", instret_count); end
    checks++; if (cycle_count !== 32'd30) begin errors++; $display("FAIL cycle_count: got %0d want 30", cycle_count); end
`endif
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_illegal();
    test_timeouts();
    test_rd0_run_drop();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
